i2s_tx_fifo: RTL and testbench

I2S_TX_FIFO -- requirements
Module: i2s_tx_fifo

---
 rtl/i2s_tx_fifo.sv | 75 +++++++
 tb/tb_i2s_tx_fifo.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: stereo-frame FIFO feeding an I2S transmitter, with priming,
// underrun handling (zero or repeat) and a low-water DMA refill request.
module i2s_tx_fifo #(
   parameter  int DEPTH = 16,
   parameter  int PRIME = 2,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push_valid,
   output logic          push_ready,
   input  logic [31:0]   push_l,
   input  logic [31:0]   push_r,
   input  logic          pop,
   output logic [31:0]   din_l,
   output logic [31:0]   din_r,
   input  logic          flush,
   input  logic [AW:0]   thresh,
   output logic          dma_req,
   output logic [AW:0]   level,
   input  logic          underrun_mode,
   output logic [15:0]   underrun_cnt,
   input  logic          clr_underrun
);
   typedef enum logic {S_PRIME, S_RUN} state_t;
   state_t state;
   logic [63:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0] level_nxt;
   logic rdy, wr, rd, ur;
   // rdy keeps push_ready low while in reset and until the first edge after release
   assign push_ready = rdy & (level != (AW+1)'(DEPTH)) & ~flush;
   assign wr = push_valid & push_ready;
   assign rd = pop & ~flush & (state == S_RUN) & (level != '0);
   assign ur = pop & ~flush & (state == S_RUN) & (level == '0);
   assign level_nxt = flush ? '0 : level + (AW+1)'(wr) - (AW+1)'(rd);
   always_ff @(posedge clk)
      if (wr) mem[wptr] <= {push_l, push_r};
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state        <= S_PRIME;
         wptr         <= '0;
         rptr         <= '0;
         level        <= '0;
         rdy          <= 1'b0;
         din_l        <= '0;
         din_r        <= '0;
         dma_req      <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         rdy     <= 1'b1;
         level   <= level_nxt;
         dma_req <= (level_nxt <= thresh) & ~flush;
         if (flush) begin
            state <= S_PRIME;
            wptr  <= '0;
            rptr  <= '0;
            din_l <= '0;
            din_r <= '0;
         end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) begin
               {din_l, din_r} <= mem[rptr];
               rptr           <= rptr + 1'b1;
            end else if (pop && (state == S_PRIME || !underrun_mode)) begin
               din_l <= '0;
               din_r <= '0;
            end
            if (state == S_PRIME && level >= (AW+1)'(PRIME)) state <= S_RUN;
         end
         if (clr_underrun) underrun_cnt <= '0;
         else if (ur && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_i2s_tx_fifo.sv
// tb_i2s_tx_fifo: randomized and directed checks of i2s_tx_fifo against a
// queue-based reference model of the frame stream.
module tb_i2s_tx_fifo;
   localparam int DEPTH = 16;
   localparam int PRIME = 2;
   localparam int AW    = 4;
   logic clk = 0, rstn = 0;
   logic push_valid = 0, pop = 0, flush = 0, clr_underrun = 0, underrun_mode = 0;
   logic [31:0] push_l = 0, push_r = 0;
   logic [AW:0] thresh = 4;
   logic push_ready, dma_req;
   logic [31:0] din_l, din_r;
   logic [AW:0] level;
   logic [15:0] underrun_cnt;
   int tests = 0, fails = 0;
   logic [63:0] q[$];
   logic [63:0] m_din = 0;
   logic [15:0] m_cnt = 0;
   bit primed = 0, m_dma = 0, m_en = 0;

   i2s_tx_fifo #(.DEPTH(DEPTH), .PRIME(PRIME)) dut (
      .clk(clk), .rstn(rstn), .push_valid(push_valid), .push_ready(push_ready),
      .push_l(push_l), .push_r(push_r), .pop(pop), .din_l(din_l), .din_r(din_r),
      .flush(flush), .thresh(thresh), .dma_req(dma_req), .level(level),
      .underrun_mode(underrun_mode), .underrun_cnt(underrun_cnt), .clr_underrun(clr_underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input bit pv, input logic [31:0] l, input logic [31:0] r,
                       input bit pp, input bit fl, input bit cl);
      bit exp_rdy;
      int n;
      @(negedge clk);
      push_valid = pv; push_l = l; push_r = r; pop = pp; flush = fl; clr_underrun = cl;
      #1;
      n = q.size();
      exp_rdy = m_en && n != DEPTH && !fl;
      check("push_ready", push_ready, exp_rdy);
      if (fl) begin
         q.delete(); m_din = 0; primed = 0;
      end else begin
         if (pp) begin
            if (!primed) m_din = 0;
            else if (n > 0) m_din = q.pop_front();
            else begin
               if (m_cnt != 16'hFFFF) m_cnt++;
               if (!underrun_mode) m_din = 0;
            end
         end
         if (pv && exp_rdy) q.push_back({l, r});
         if (n >= PRIME) primed = 1;
      end
      if (cl) m_cnt = 0;
      m_dma = !fl && q.size() <= int'(thresh);
      m_en = 1;
      @(posedge clk); #1;
      check("level", level, q.size());
      check("din", {din_l, din_r}, m_din);
      check("dma_req", dma_req, m_dma);
      check("underrun_cnt", underrun_cnt, m_cnt);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rstn = 0; push_valid = 0; pop = 0; flush = 0; clr_underrun = 0;
      #1;
      check("rst_push_ready", push_ready, 0);
      check("rst_din", {din_l, din_r}, 0);
      check("rst_level", level, 0);
      check("rst_dma_req", dma_req, 0);
      check("rst_underrun_cnt", underrun_cnt, 0);
      repeat (2) @(negedge clk);
      rstn = 1;
      q.delete(); primed = 0; m_din = 0; m_cnt = 0; m_en = 1; m_dma = 1;
      @(posedge clk); #1;
      check("first_push_ready", push_ready, 1);
      check("first_dma_req", dma_req, 1);
   endtask

   task automatic idle(); step(0, 0, 0, 0, 0, 0); endtask
   task automatic push(input logic [31:0] l, input logic [31:0] r); step(1, l, r, 0, 0, 0); endtask
   task automatic pop1(); step(0, 0, 0, 1, 0, 0); endtask

   initial begin
      thresh = 4;
      underrun_mode = 0;
      do_reset();
      // basic priming and first pop
      push(32'h11, 32'h22);
      push(32'h33, 32'h44);
      idle();
      pop1();
      check("first_frame", {din_l, din_r}, {32'h11, 32'h22});
      pop1();
      // fill to full across the pointer wrap, then drain
      for (int i = 0; i < DEPTH; i++) push($urandom, $urandom);
      check("full_level", level, DEPTH);
      push(32'hDEAD, 32'hBEEF);
      for (int i = 0; i < DEPTH; i++) pop1();
      // underruns in both modes
      underrun_mode = 0;
      pop1();
      underrun_mode = 1;
      push(32'hA5A5, 32'h5A5A);
      pop1();
      pop1();
      check("repeat_frame", {din_l, din_r}, {32'hA5A5, 32'h5A5A});
      // pop with simultaneous push while empty
      step(1, 32'h77, 32'h88, 1, 0, 0);
      pop1();
      // pop before priming is ignored
      step(0, 0, 0, 0, 1, 0);
      push(32'h99, 32'hAA);
      pop1();
      // low-water crossings
      thresh = 4;
      for (int i = 0; i < 4; i++) push($urandom, $urandom);
      idle();
      pop1();
      push($urandom, $urandom);
      idle();
      // flush with push and pop pending
      for (int i = 0; i < 2; i++) push($urandom, $urandom);
      check("pre_flush_level", level, 7);
      step(1, $urandom, $urandom, 1, 1, 0);
      // clear racing an underrun
      push(1, 2); push(3, 4); idle(); pop1(); pop1();
      step(0, 0, 0, 1, 0, 1);
      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         if (i % 100 == 0) begin
            thresh = AW'($urandom_range(0, DEPTH));
            underrun_mode = $urandom_range(0, 1);
         end
         step($urandom_range(0, 2) != 0, $urandom, $urandom, $urandom_range(0, 2) == 0,
              $urandom_range(0, 59) == 0, $urandom_range(0, 49) == 0);
      end
      // reset mid-operation discards everything
      for (int i = 0; i < 5; i++) push($urandom, $urandom);
      do_reset();
      check("post_reset_level", level, 0);
      push(5, 6); push(7, 8); idle(); pop1();
      check("post_reset_frame", {din_l, din_r}, {32'h5, 32'h6});
      pop1();
      // saturate the underrun counter
      for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) pop1();
      pop1();
      pop1();
      check("saturated", underrun_cnt, 16'hFFFF);
      step(0, 0, 0, 1, 0, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
